// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b, one bit slice per clock, LSB first.
// A start pulse loads the operands; done pulses for one cycle when diff/borrow are final.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned SW = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [SW-1:0]    sd_q, sd_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic slice_d_c;
    logic slice_bo_c;
    logic load_c;

    // Full-subtractor bit slice on the current LSBs and the running borrow
    always_comb begin
        slice_d_c  = sa_q[0] ^ sb_q[0] ^ br_q;
        slice_bo_c = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    end

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        sd_d     = sd_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        load_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) load_c = 1'b1;
            end
            S_SHIFT: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                // sd holds only the WIDTH-1 bits gathered so far; the last slice joins at the top
                sd_d  = SW'({slice_d_c, sd_q} >> 1);
                br_d  = slice_bo_c;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    diff_d   = {slice_d_c, sd_q};
                    borrow_d = slice_bo_c;
                end
            end
            S_DONE: begin
                if (start) load_c = 1'b1;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (load_c) begin
            state_d = S_SHIFT;
            sa_d    = a;
            sb_d    = b;
            sd_d    = '0;
            br_d    = 1'b0;
            cnt_d   = '0;
        end

        busy_d = (state_d == S_SHIFT);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            sd_q     <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            sd_q     <= sd_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and table-driven checks for serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow;

    int errors;
    int checks;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       br;
    } vec_t;

    vec_t vecs[10];

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Presents operands with start for one edge; returns at the negedge after acceptance
    task automatic launch(input logic [7:0] av, input logic [7:0] bv);
        @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits for done, starting 'elapsed' negedges after acceptance; returns on the done cycle
    task automatic wait_done(input logic [7:0] ed, input logic eb, input int elapsed, input string nm);
        int cyc;
        int bc;
        cyc = elapsed;
        bc  = 0;
        while (done !== 1'b1 && cyc < elapsed + 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            cyc++;
        end
        check({nm, "_done"},    32'(done),   32'd1);
        check({nm, "_latency"}, 32'(cyc),    32'd8);
        check({nm, "_busycyc"}, 32'(bc),     32'(8 - elapsed));
        check({nm, "_busy0"},   32'(busy),   32'd0);
        check({nm, "_diff"},    32'(diff),   32'(ed));
        check({nm, "_borrow"},  32'(borrow), 32'(eb));
    endtask

    task automatic full_op(input logic [7:0] av, input logic [7:0] bv,
                           input logic [7:0] ed, input logic eb, input string nm);
        launch(av, bv);
        wait_done(ed, eb, 0, nm);
        @(negedge clk);
        check({nm, "_pulse"}, 32'(done), 32'd0);
        check({nm, "_idle"},  32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        logic [7:0] ra;
        logic [7:0] rb;

        errors = 0;
        checks = 0;
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
        vecs[2] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 1'b0};
        vecs[4] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[6] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        vecs[7] = '{8'h01, 8'h80, 8'h81, 1'b1};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vecs[9] = '{8'hAA, 8'h55, 8'h55, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_diff",   32'(diff),   32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            full_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, $sformatf("vec%0d", i));
        end

        // Random pairs against the plain arithmetic reference
        for (int i = 0; i < 120; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            full_op(ra, rb, 8'(ra - rb), ra < rb, $sformatf("rnd%0d_%0h_%0h", i, ra, rb));
        end

        // start and new operands during SHIFT must be ignored
        launch(8'h05, 8'h03);
        repeat (2) @(negedge clk);
        a     = 8'hAA;
        b     = 8'h11;
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(8'h02, 1'b0, 4, "ignore");
        @(negedge clk);
        check("ignore_pulse", 32'(done), 32'd0);
        check("ignore_idle",  32'(busy), 32'd0);

        // Back-to-back: start held in the DONE cycle
        launch(8'h10, 8'h20);
        wait_done(8'hF0, 1'b1, 0, "b2b_first");
        a     = 8'hFF;
        b     = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy",  32'(busy), 32'd1);
        check("b2b_done0", 32'(done), 32'd0);
        check("b2b_held",  32'(diff), 32'hF0);
        wait_done(8'hFE, 1'b0, 0, "b2b_second");
        @(negedge clk);
        check("b2b_pulse", 32'(done), 32'd0);

        // Reset in the middle of an operation
        full_op(8'h03, 8'h05, 8'hFE, 1'b1, "pre_rst");
        launch(8'h05, 8'h03);
        repeat (3) @(negedge clk);
        check("midrst_busy_before", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy",   32'(busy),   32'd0);
        check("midrst_done",   32'(done),   32'd0);
        check("midrst_diff",   32'(diff),   32'd0);
        check("midrst_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        check("midrst_nodone", 32'(dcnt), 32'd0);
        check("midrst_idle",   32'(busy), 32'd0);
        full_op(8'h80, 8'h01, 8'h7F, 1'b0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
